// File: rtl/dm_resp_pkg.sv
// Shared types and constants for the data-memory responder: FSM states, request record, index width.
package dm_resp_pkg;

  localparam int WORD_W = 32;
  localparam int LANES  = 4;

  typedef enum logic [1:0] {IDLE, WAIT, ACCESS, RESP} state_t;

  typedef struct packed {
    logic              we;
    logic [WORD_W-1:0] addr;
    logic [WORD_W-1:0] wdata;
    logic [LANES-1:0]  be;
  } req_t;

  function automatic int idx_width(input int depth);
    return (depth > 1) ? $clog2(depth) : 1;
  endfunction

endpackage

// File: rtl/dm_resp_if.sv
// Request/response bundle between the core's data port (master) and the memory responder (slave).
interface dm_resp_if import dm_resp_pkg::*;;

  logic              req_valid;
  logic              req_ready;
  logic              req_we;
  logic [WORD_W-1:0] req_addr;
  logic [WORD_W-1:0] req_wdata;
  logic [LANES-1:0]  req_be;
  logic              resp_valid;
  logic              resp_ready;
  logic [WORD_W-1:0] resp_rdata;
  logic              resp_err;

  modport master (
    output req_valid, req_we, req_addr, req_wdata, req_be, resp_ready,
    input  req_ready, resp_valid, resp_rdata, resp_err
  );

  modport slave (
    input  req_valid, req_we, req_addr, req_wdata, req_be, resp_ready,
    output req_ready, resp_valid, resp_rdata, resp_err
  );

endinterface

// File: rtl/dm_resp_array.sv
// Word storage with byte-masked synchronous write and registered read; no reset, contents persist.
module dm_resp_array import dm_resp_pkg::*; #(
  parameter int DEPTH = 1024,
  parameter int IW    = idx_width(DEPTH)
) (
  input  logic              clk,
  input  logic              we,
  input  logic [IW-1:0]     idx,
  input  logic [WORD_W-1:0] wdata,
  input  logic [LANES-1:0]  be,
  output logic [WORD_W-1:0] rdata
);

  logic [WORD_W-1:0] mem [DEPTH];

  always_ff @(posedge clk) begin
    if (we) begin
      for (int i = 0; i < LANES; i++) begin
        if (be[i]) mem[idx][8*i +: 8] <= wdata[8*i +: 8];
      end
    end
    rdata <= mem[idx];
  end

endmodule

// File: rtl/dm_responder.sv
// Data-port memory responder: one request at a time, response WAIT_CYCLES+2 edges after presentation, held until resp_ready.
// No new request accepted until RESP handshake completes. Optional address fault checking via DM_RESP_ADDR_CHECK_EN.
module dm_responder import dm_resp_pkg::*; #(
  parameter int DEPTH       = 1024,
  parameter int WAIT_CYCLES = 2
) (
  input  logic     clk,
  input  logic     rst,
  dm_resp_if.slave bus
);

  localparam int         IW       = idx_width(DEPTH);
  localparam logic [3:0] CNT_INIT = (WAIT_CYCLES > 0) ? 4'(WAIT_CYCLES - 1) : 4'd0;

  state_t            state, state_nxt;
  logic [3:0]        cnt, cnt_nxt;
  req_t              req_q;
  logic              err_q;
  logic              rdy_q;
  logic              accept;
  logic              addr_bad;
  logic              arr_we;
  logic [WORD_W-1:0] arr_rdata;

  assign accept = bus.req_valid && rdy_q;

  always_comb begin
    state_nxt = state;
    cnt_nxt   = cnt;
    case (state)
      IDLE: begin
        if (accept) begin
          if (WAIT_CYCLES == 0) begin
            state_nxt = ACCESS;
          end else begin
            state_nxt = WAIT;
            cnt_nxt   = CNT_INIT;
          end
        end
      end
      WAIT: begin
        if (cnt == 4'd0) state_nxt = ACCESS;
        else             cnt_nxt   = cnt - 4'd1;
      end
      ACCESS:  state_nxt = RESP;
      RESP:    if (bus.resp_ready) state_nxt = IDLE;
      default: state_nxt = IDLE;
    endcase
  end

  // req_ready is registered so it stays low throughout reset and rises on the first edge after release.
  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      state <= IDLE;
      cnt   <= 4'd0;
      rdy_q <= 1'b0;
    end else begin
      state <= state_nxt;
      cnt   <= cnt_nxt;
      rdy_q <= (state_nxt == IDLE);
    end
  end

  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      req_q <= '0;
      err_q <= 1'b0;
    end else begin
      if (accept) begin
        req_q <= '{we: bus.req_we, addr: bus.req_addr, wdata: bus.req_wdata, be: bus.req_be};
      end
      if (state == ACCESS) err_q <= addr_bad;
    end
  end

`ifdef DM_RESP_ADDR_CHECK_EN
  assign addr_bad = (req_q.addr[1:0] != 2'b00) || (req_q.addr[WORD_W-1:IW+2] != '0);
`else
  // Byte offset and bits above the storage range are ignored, so addresses alias modulo 4*DEPTH.
  logic unused_addr;
  assign unused_addr = ^{req_q.addr[WORD_W-1:IW+2], req_q.addr[1:0]};
  assign addr_bad    = 1'b0;
`endif

  assign arr_we = (state == ACCESS) && req_q.we && !addr_bad;

  dm_resp_array #(.DEPTH(DEPTH), .IW(IW)) u_array (
    .clk   (clk),
    .we    (arr_we),
    .idx   (req_q.addr[IW+1:2]),
    .wdata (req_q.wdata),
    .be    (req_q.be),
    .rdata (arr_rdata)
  );

  // The array read register is loaded on the ACCESS edge and idx is frozen until the next accept, so data holds in RESP.
  assign bus.req_ready  = rdy_q;
  assign bus.resp_valid = (state == RESP);
  assign bus.resp_err   = (state == RESP) && err_q;
  assign bus.resp_rdata = ((state == RESP) && !req_q.we && !err_q) ? arr_rdata : '0;

endmodule

// File: tb/tb_dm_responder.sv
// Self-checking bench for dm_responder: vector table, hand-written corner sequences and a randomized run against a memory model.
module tb_dm_responder;
  import dm_resp_pkg::*;

  localparam int DEPTH = 1024;

  logic clk = 1'b0;
  logic rst;
  always #5 clk = ~clk;

  dm_resp_if a ();
  dm_resp_if b ();

  dm_responder #(.DEPTH(DEPTH), .WAIT_CYCLES(2)) u_w2 (.clk(clk), .rst(rst), .bus(a));
  dm_responder #(.DEPTH(DEPTH), .WAIT_CYCLES(0)) u_w0 (.clk(clk), .rst(rst), .bus(b));

  int errors = 0;
  int checks = 0;
  int cyc    = 0;
  always @(posedge clk) cyc++;

  typedef struct {
    logic        we;
    logic [31:0] addr;
    logic [31:0] wdata;
    logic [3:0]  be;
    logic [31:0] exp_rd;
    logic        exp_err;
  } vec_t;

  logic [31:0] mdl_mem [DEPTH];
  bit          known   [DEPTH];

  task automatic chk(input string name, input logic [31:0] got, input logic [31:0] exp);
    checks++;
    if (got !== exp) begin
      errors++;
      $display("FAIL %s: got 0x%08h, expected 0x%08h", name, got, exp);
    end
  endtask

  task automatic fail_to(input string name);
    checks++;
    errors++;
    $display("FAIL %s: handshake did not occur within cycle bound", name);
  endtask

  task automatic set_req(input int sel, input logic v, input logic we, input logic [31:0] addr,
                         input logic [31:0] wdata, input logic [3:0] be);
    if (sel == 0) begin
      a.req_valid = v; a.req_we = we; a.req_addr = addr; a.req_wdata = wdata; a.req_be = be;
    end else begin
      b.req_valid = v; b.req_we = we; b.req_addr = addr; b.req_wdata = wdata; b.req_be = be;
    end
  endtask

  function automatic logic get_rdy(input int sel);
    return (sel == 0) ? a.req_ready : b.req_ready;
  endfunction
  function automatic logic get_rv(input int sel);
    return (sel == 0) ? a.resp_valid : b.resp_valid;
  endfunction
  function automatic logic [31:0] get_rd(input int sel);
    return (sel == 0) ? a.resp_rdata : b.resp_rdata;
  endfunction
  function automatic logic get_err(input int sel);
    return (sel == 0) ? a.resp_err : b.resp_err;
  endfunction

  // Called just after a rising edge; returns just after the response handshake edge.
  // lat counts edges from request presentation (accepting edge = 1) to the edge raising resp_valid.
  task automatic txn(input int sel, input logic we, input logic [31:0] addr, input logic [31:0] wdata,
                     input logic [3:0] be, output logic [31:0] rd, output logic er, output int lat);
    int   n;
    logic acc;
    rd = '0; er = 1'b0; lat = 0;
    set_req(sel, 1'b1, we, addr, wdata, be);
    n = 0; acc = 1'b0;
    while (!acc && n < 50) begin
      @(negedge clk); acc = get_rdy(sel);
      @(posedge clk); n++;
    end
    #1 set_req(sel, 1'b0, 1'b0, 32'h0, 32'h0, 4'h0);
    if (!acc) begin fail_to("accept"); return; end
    lat = 1; acc = 1'b0;
    while (!acc && lat < 50) begin
      @(negedge clk); acc = get_rv(sel);
      if (!acc) begin @(posedge clk); lat++; end
    end
    if (!acc) begin fail_to("response"); return; end
    rd = get_rd(sel);
    er = get_err(sel);
    @(posedge clk); #1;
  endtask

  function automatic logic mdl_err(input logic [31:0] addr);
`ifdef DM_RESP_ADDR_CHECK_EN
    return (addr[1:0] != 2'b00) || (addr >= 32'(4 * DEPTH));
`else
    return 1'b0;
`endif
  endfunction

  function automatic int mdl_idx(input logic [31:0] addr);
    return int'((addr / 4) % DEPTH);
  endfunction

  task automatic mdl_store(input logic [31:0] addr, input logic [31:0] wdata, input logic [3:0] be);
    int          idx;
    logic [31:0] w;
    if (mdl_err(addr)) return;
    idx = mdl_idx(addr);
    w   = mdl_mem[idx];
    for (int i = 0; i < 4; i++) if (be[i]) w[8*i +: 8] = wdata[8*i +: 8];
    mdl_mem[idx] = w;
    if (be == 4'hF) known[idx] = 1'b1;
  endtask

  initial begin
    #2_000_000;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1, "watchdog");
  end

  initial begin
    vec_t        tbl[$];
    logic [31:0] rd, first_rd;
    logic        er, acc;
    int          lat, n, t0;

    rst = 1'b0;
    set_req(0, 1'b0, 1'b0, 32'h0, 32'h0, 4'h0);
    set_req(1, 1'b0, 1'b0, 32'h0, 32'h0, 4'h0);
    a.resp_ready = 1'b1;
    b.resp_ready = 1'b1;
    for (int i = 0; i < DEPTH; i++) known[i] = 1'b0;

    // Reset state, then a reset pulse while idle.
    repeat (2) @(negedge clk);
    chk("rst_req_ready", 32'(a.req_ready), 32'h0);
    chk("rst_resp_valid", 32'(a.resp_valid), 32'h0);
    chk("rst_resp_rdata", a.resp_rdata, 32'h0);
    chk("rst_resp_err", 32'(a.resp_err), 32'h0);
    rst = 1'b1;
    @(negedge clk);
    chk("post_rst_req_ready", 32'(a.req_ready), 32'h1);
    rst = 1'b0;
    #1 chk("pulse_req_ready", 32'(a.req_ready), 32'h0);
    @(negedge clk);
    chk("pulse_req_ready_held", 32'(a.req_ready), 32'h0);
    rst = 1'b1;
    @(negedge clk);
    chk("pulse_release_ready", 32'(a.req_ready), 32'h1);
    @(posedge clk); #1;

    tbl.push_back('{1'b1, 32'h10,   32'hDEADBEEF, 4'hF, 32'h0,        1'b0});
    tbl.push_back('{1'b0, 32'h10,   32'h0,        4'h0, 32'hDEADBEEF, 1'b0});
    tbl.push_back('{1'b1, 32'h20,   32'h11223344, 4'hF, 32'h0,        1'b0});
    tbl.push_back('{1'b1, 32'h20,   32'hAABBCCDD, 4'h5, 32'h0,        1'b0});
    tbl.push_back('{1'b0, 32'h20,   32'h0,        4'h0, 32'h11BB33DD, 1'b0});
    tbl.push_back('{1'b1, 32'h20,   32'hFFFFFFFF, 4'h0, 32'h0,        1'b0});
    tbl.push_back('{1'b0, 32'h20,   32'h0,        4'h0, 32'h11BB33DD, 1'b0});
    tbl.push_back('{1'b1, 32'h40,   32'h00000005, 4'hF, 32'h0,        1'b0});
    tbl.push_back('{1'b1, 32'h0,    32'h01020304, 4'hF, 32'h0,        1'b0});
`ifdef DM_RESP_ADDR_CHECK_EN
    tbl.push_back('{1'b1, 32'h1002, 32'hCAFEF00D, 4'hF, 32'h0,        1'b1});
    tbl.push_back('{1'b1, 32'h1000, 32'hCAFEF00D, 4'hF, 32'h0,        1'b1});
    tbl.push_back('{1'b0, 32'h1000, 32'h0,        4'h0, 32'h0,        1'b1});
    tbl.push_back('{1'b0, 32'h13,   32'h0,        4'h0, 32'h0,        1'b1});
    tbl.push_back('{1'b0, 32'h0,    32'h0,        4'h0, 32'h01020304, 1'b0});
`else
    tbl.push_back('{1'b1, 32'h1000, 32'hCAFEF00D, 4'hF, 32'h0,        1'b0});
    tbl.push_back('{1'b0, 32'h0,    32'h0,        4'h0, 32'hCAFEF00D, 1'b0});
    tbl.push_back('{1'b0, 32'h1012, 32'h0,        4'h0, 32'hDEADBEEF, 1'b0});
`endif

    foreach (tbl[i]) begin
      txn(0, tbl[i].we, tbl[i].addr, tbl[i].wdata, tbl[i].be, rd, er, lat);
      chk($sformatf("vec%0d_rdata", i), rd, tbl[i].exp_rd);
      chk($sformatf("vec%0d_err", i), 32'(er), 32'(tbl[i].exp_err));
      chk($sformatf("vec%0d_latency", i), 32'(lat), 32'd4);
      if (tbl[i].we) mdl_store(tbl[i].addr, tbl[i].wdata, tbl[i].be);
    end

    // Response backpressure: hold resp_ready low for 5 cycles while a second request waits.
    a.resp_ready = 1'b0;
    set_req(0, 1'b1, 1'b0, 32'h10, 32'h0, 4'h0);
    @(posedge clk); #1;
    set_req(0, 1'b1, 1'b0, 32'h20, 32'h0, 4'h0);
    n = 0;
    @(negedge clk);
    while (!a.resp_valid && n < 20) begin @(negedge clk); n++; end
    if (!a.resp_valid) fail_to("bp_first_resp");
    first_rd = a.resp_rdata;
    chk("bp_first_rdata", first_rd, 32'hDEADBEEF);
    for (int k = 0; k < 5; k++) begin
      chk($sformatf("bp_valid_%0d", k), 32'(a.resp_valid), 32'h1);
      chk($sformatf("bp_rdata_%0d", k), a.resp_rdata, first_rd);
      chk($sformatf("bp_req_ready_%0d", k), 32'(a.req_ready), 32'h0);
      @(negedge clk);
    end
    a.resp_ready = 1'b1;
    @(posedge clk);
    @(negedge clk);
    chk("bp_after_hs_ready", 32'(a.req_ready), 32'h1);
    chk("bp_after_hs_valid", 32'(a.resp_valid), 32'h0);
    chk("bp_after_hs_rdata", a.resp_rdata, 32'h0);
    n = 0; acc = 1'b0;
    while (!acc && n < 20) begin
      @(posedge clk); n++;
      if (n == 1) #1 set_req(0, 1'b0, 1'b0, 32'h0, 32'h0, 4'h0);
      @(negedge clk); acc = a.resp_valid;
    end
    chk("bp_second_latency", 32'(n), 32'd4);
    chk("bp_second_rdata", a.resp_rdata, 32'h11BB33DD);
    @(posedge clk); #1;

    // Reset during WAIT drops the pending store to 0x40.
    set_req(0, 1'b1, 1'b1, 32'h40, 32'h00000099, 4'hF);
    @(posedge clk); #1;
    set_req(0, 1'b0, 1'b0, 32'h0, 32'h0, 4'h0);
    @(negedge clk);
    rst = 1'b0;
    #1;
    chk("midrst_req_ready", 32'(a.req_ready), 32'h0);
    chk("midrst_valid_0", 32'(a.resp_valid), 32'h0);
    for (int k = 1; k < 4; k++) begin
      @(negedge clk);
      chk($sformatf("midrst_valid_%0d", k), 32'(a.resp_valid), 32'h0);
    end
    rst = 1'b1;
    @(posedge clk); #1;
    txn(0, 1'b0, 32'h40, 32'h0, 4'h0, rd, er, lat);
    chk("midrst_load_0x40", rd, 32'h00000005);
    chk("midrst_load_latency", 32'(lat), 32'd4);

    // Zero wait states.
    txn(1, 1'b1, 32'h0, 32'h0BADF00D, 4'hF, rd, er, lat);
    chk("zw_store_latency", 32'(lat), 32'd2);
    chk("zw_store_rdata", rd, 32'h0);
    txn(1, 1'b0, 32'h0, 32'h0, 4'h0, rd, er, lat);
    chk("zw_load_latency", 32'(lat), 32'd2);
    chk("zw_load_rdata", rd, 32'h0BADF00D);
    t0 = cyc;
    for (int k = 0; k < 10; k++) txn(1, 1'b0, 32'h0, 32'h0, 4'h0, rd, er, lat);
    chk("zw_10_loads_cycles", 32'(cyc - t0), 32'd30);
    chk("zw_last_rdata", rd, 32'h0BADF00D);

    // Randomized traffic checked against the memory model; fill a working region first.
    for (int w = 0; w < 64; w++) begin
      logic [31:0] d;
      d = $urandom;
      txn(0, 1'b1, 32'(w * 4), d, 4'hF, rd, er, lat);
      chk($sformatf("fill%0d_err", w), 32'(er), 32'h0);
      mdl_store(32'(w * 4), d, 4'hF);
    end
    for (int k = 0; k < 150; k++) begin
      logic        we, e_err;
      logic [31:0] addr, wdata;
      logic [3:0]  be;
      int          r, idx;
      we    = 1'($urandom_range(1, 0));
      r     = $urandom_range(3, 0);
      addr  = (r == 0) ? $urandom : 32'($urandom_range(63, 0) * 4 + ((r == 1) ? $urandom_range(3, 0) : 0));
      wdata = $urandom;
      be    = 4'($urandom_range(15, 0));
      e_err = mdl_err(addr);
      idx   = mdl_idx(addr);
      txn(0, we, addr, wdata, be, rd, er, lat);
      chk($sformatf("rnd%0d_err a=%08h", k, addr), 32'(er), 32'(e_err));
      chk($sformatf("rnd%0d_latency", k), 32'(lat), 32'd4);
      if (we || e_err) chk($sformatf("rnd%0d_rdata_zero a=%08h", k, addr), rd, 32'h0);
      else if (known[idx]) chk($sformatf("rnd%0d_load a=%08h", k, addr), rd, mdl_mem[idx]);
      if (we) mdl_store(addr, wdata, be);
    end

    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

endmodule

// File: doc/dm_responder.md
Name: dm_responder

Overview:
- Memory-side responder for the pipelined MIPS core's data port.
- Accepts one load or store request at a time over a valid/ready handshake.
- Inserts a configurable number of wait states and returns a registered response. The core must therefore stall on memory instead of assuming single-cycle data memory.
- Holds its own word-addressed 4 KB (default) storage with byte-enable writes.

Parameters:
- DEPTH, 1024, number of 32-bit words in storage; power of two, at least 2.
- WAIT_CYCLES, 2, extra cycles between request acceptance and the memory access; range 0..15.

Ports:
- clk  input  1  system clock; all state changes on the rising edge.
- rst  input  1  asynchronous, active-low reset.
- req_valid  input  1  initiator presents a request.
- req_ready  output  1  responder can accept a request this cycle.
- req_we  input  1  1 = store, 0 = load.
- req_addr  input  32  byte address.
- req_wdata  input  32  store data.
- req_be  input  4  byte enables for stores; bit i enables byte lane [8i+7:8i].
- resp_valid  output  1  response available.
- resp_ready  input  1  initiator accepts the response.
- resp_rdata  output  32  load data; 0 for stores and for errors.
- resp_err  output  1  request faulted.

Behaviour:
- States: IDLE, WAIT, ACCESS, RESP.
- Reset (rst=0, asynchronous):
  - State goes to IDLE and the wait counter to 0.
  - req_ready=0 while rst is low, and 1 from the first edge after release.
  - resp_valid=0, resp_rdata=0, resp_err=0.
  - Storage contents are not cleared.
- Reset asserted mid-transaction: the transaction is dropped. A store whose ACCESS cycle has not yet occurred is never committed.
- IDLE:
  - req_ready=1.
  - A handshake (req_valid && req_ready) latches we, addr, wdata and be.
  - Next state is WAIT with counter=WAIT_CYCLES-1, or ACCESS if WAIT_CYCLES=0.
- WAIT:
  - req_ready=0.
  - The counter decrements each cycle; at 0 the next state is ACCESS.
- ACCESS (one cycle):
  - Word index = latched addr[log2(DEPTH)+1:2].
  - Store: lanes with be=1 are written on this edge; other lanes are unchanged.
  - Load: word read into resp_rdata.
  - resp_err is registered.
  - Next state is RESP.
- RESP:
  - resp_valid=1, and resp_rdata/resp_err are held stable until resp_valid && resp_ready.
  - On that handshake the next state is IDLE. resp_valid drops the following cycle and resp_rdata/resp_err clear to 0.
- No back-to-back acceptance: req_ready is low from the accept cycle's edge until the state returns to IDLE.
- Latency: resp_valid rises WAIT_CYCLES+2 edges after the accepting edge.
- Throughput: one request per WAIT_CYCLES+3 cycles with resp_ready held high.
- req_valid asserted outside IDLE is ignored; the initiator must hold it.
- Store with be=0000: no lanes written, response returns with resp_err=0.
- Load-after-store to the same word sees the stored data, because accesses are strictly serialised.

Optional Feature:
- Macro DM_RESP_ADDR_CHECK_EN.
- Defined:
  - A request faults if addr[1:0]!=0 or addr >= 4*DEPTH.
  - A faulting request performs no write, returns resp_rdata=0 and resp_err=1, and keeps the same latency.
- Undefined:
  - addr[1:0] is ignored and the upper address bits are ignored, so addresses wrap modulo 4*DEPTH.
  - resp_err is tied to 0.

Decomposition:
- Package dm_resp_pkg holds:
  - state enum {IDLE, WAIT, ACCESS, RESP};
  - the word-width constant 32;
  - the byte-lane count 4;
  - a function computing the index width from DEPTH.
- Sub-module dm_resp_array contains the storage and nothing else:
  - inputs: clk, we, idx, wdata, be;
  - output: rdata;
  - synchronous byte-masked write and registered read;
  - no reset.
- The FSM, wait counter and handshake logic stay in dm_responder.

Test Plan:
- Reset then store: WAIT_CYCLES=2, rst pulsed low mid-idle, then store addr=0x10, wdata=0xDEADBEEF, be=1111, resp_ready=1 → req_ready 0 during rst; resp_valid exactly 4 edges after accept; resp_err=0; a load from 0x10 returns 0xDEADBEEF.
- Partial store: store 0x11223344 at 0x20, then store 0xAABBCCDD with be=0101 at 0x20, then load 0x20 → 0x11BB33DD.
- Response backpressure: load with resp_ready=0 for 5 cycles → resp_valid and resp_rdata stable all 5 cycles; req_ready stays 0; a second req_valid is not accepted until the cycle after the resp handshake.
- Zero wait states: WAIT_CYCLES=0, load 0x0 → resp_valid 2 edges after accept; 10 consecutive loads with resp_ready=1 complete in 30 cycles.
- Address check: with DM_RESP_ADDR_CHECK_EN, store to 0x1002 and to 0x1000 (DEPTH=1024) → resp_err=1 and memory unchanged. Without the macro, a store to 0x1000 → overwrites word 0, resp_err=0.
- Reset mid-operation: accept store to 0x40 (old value 0x5), assert rst during WAIT → after release, load 0x40 returns 0x5; resp_valid stayed 0 through reset.
